unified_memory: RTL

//  Byte-addressed unified instruction/data memory directly downstream of the multicycle riscv core.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/unified_memory_if.sv | 23 ++
 rtl/unified_memory_load_align.sv | 40 ++++
 rtl/unified_memory.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, MMIO offsets and access-size helpers for the unified instruction/data memory.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    localparam logic [3:0] MMIO_LED_OFF   = 4'h0;
    localparam logic [3:0] MMIO_CNTLO_OFF = 4'h4;
    localparam logic [3:0] MMIO_CNTHI_OFF = 4'h8;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 64;

    // log2 of access size in bytes; unused encodings behave as word
    function automatic logic [1:0] access_lg2(input logic [2:0] f3);
        case (f3)
            MEM_B, MEM_BU: return 2'd0;
            MEM_H, MEM_HU: return 2'd1;
            default:       return 2'd2;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] lg2, input logic [1:0] lo);
        return (lg2 == 2'd0) || ((lg2 == 2'd1) && !lo[0]) || (lo == 2'b00);
    endfunction

endpackage

// File: rtl/unified_memory_if.sv
// Core-side memory bus: address/strobe/data/size going in, read result and alignment flag coming back.
interface unified_memory_if;
    import mem_pkg::*;

    logic [XLEN-1:0] Adr;
    logic            MemWrite;
    logic [XLEN-1:0] WriteData;
    logic [2:0]      funct3;
    logic            LoadExt;
    logic [XLEN-1:0] ReadData;
    logic            Misaligned;

    modport master (
        output Adr, MemWrite, WriteData, funct3, LoadExt,
        input  ReadData, Misaligned
    );

    modport slave (
        input  Adr, MemWrite, WriteData, funct3, LoadExt,
        output ReadData, Misaligned
    );

endinterface

// File: rtl/unified_memory_load_align.sv
// Picks the addressed byte/half lane from a raw word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lo,
    input  logic [2:0]      funct3,
    input  logic            ext,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = word[7:0];
        case (lo)
            2'd1:    byte_c = word[15:8];
            2'd2:    byte_c = word[23:16];
            2'd3:    byte_c = word[31:24];
            default: byte_c = word[7:0];
        endcase
        half_c = lo[1] ? word[31:16] : word[15:0];
    end

    // Fetches and unused encodings pass the raw word through
    always_comb begin
        data_c = word;
        if (ext) begin
            case (funct3)
                MEM_B:   data_c = {{24{byte_c[7]}}, byte_c};
                MEM_BU:  data_c = {24'd0, byte_c};
                MEM_H:   data_c = {{16{half_c[15]}}, half_c};
                MEM_HU:  data_c = {16'd0, half_c};
                default: data_c = word;
            endcase
        end
    end

endmodule

// File: rtl/unified_memory.sv
// Unified I/D RAM with byte-lane stores, registered aligned/extended reads, and an MMIO window
// holding the LED register and a 64-bit cycle counter with a coherent hi-word shadow.
module unified_memory
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LED_W     = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic             clk,
    input  logic             reset,
    unified_memory_if.slave  bus,
    output logic [LED_W-1:0] leds
);

    localparam int unsigned AW  = $clog2(MEM_WORDS);
    localparam int unsigned WOW = 14;

    logic [XLEN-1:0]  ram [MEM_WORDS];
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  hi_shadow;

    logic [AW-1:0]    idx_c;
    logic [WOW-1:0]   woff_c;
    logic [1:0]       lo_c;
    logic             mmio_sel_c, led_hit_c, lo_hit_c, hi_hit_c;
    logic [1:0]       st_lg2_c, ld_lg2_c;
    logic             mis_c, do_store_c;
    logic [3:0]       be_c;
    logic [XLEN-1:0]  wdata_c, mmio_rd_c, raw_c, ext_c;
    logic [LED_W-1:0] led_next_c;

    assign idx_c      = bus.Adr[AW+1:2];
    assign woff_c     = bus.Adr[15:2];
    assign lo_c       = bus.Adr[1:0];
    assign mmio_sel_c = (bus.Adr[31:16] == MMIO_BASE[31:16]);
    assign led_hit_c  = mmio_sel_c && (woff_c == WOW'(MMIO_LED_OFF >> 2));
    assign lo_hit_c   = mmio_sel_c && (woff_c == WOW'(MMIO_CNTLO_OFF >> 2));
    assign hi_hit_c   = mmio_sel_c && (woff_c == WOW'(MMIO_CNTHI_OFF >> 2));

    // Access size, alignment check and store lane steering
    always_comb begin
        st_lg2_c   = access_lg2(bus.funct3);
        ld_lg2_c   = bus.LoadExt ? st_lg2_c : 2'd2;
        mis_c      = bus.MemWrite ? !is_aligned(st_lg2_c, lo_c) : !is_aligned(ld_lg2_c, lo_c);
        do_store_c = bus.MemWrite && !mis_c;
        case (st_lg2_c)
            2'd0: begin
                be_c    = 4'b0001 << lo_c;
                wdata_c = {4{bus.WriteData[7:0]}};
            end
            2'd1: begin
                be_c    = lo_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{bus.WriteData[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = bus.WriteData;
            end
        endcase
    end

    always_comb begin
        led_next_c = leds;
        for (int i = 0; i < int'(LED_W); i++) begin
            if (be_c[i/8]) led_next_c[i] = wdata_c[i];
        end
    end

    always_comb begin
        mmio_rd_c = '0;
        if (led_hit_c)     mmio_rd_c = XLEN'(leds);
        else if (lo_hit_c) mmio_rd_c = cnt[31:0];
        else if (hi_hit_c) mmio_rd_c = hi_shadow;
        raw_c = mmio_sel_c ? mmio_rd_c : ram[idx_c];
    end

    load_align u_load_align (
        .word   (raw_c),
        .lo     (lo_c),
        .funct3 (bus.funct3),
        .ext    (bus.LoadExt),
        .data_c (ext_c)
    );

    // RAM contents survive reset; a store coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (!reset && do_store_c && !mmio_sel_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) ram[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ReadData   <= '0;
            bus.Misaligned <= 1'b0;
            leds           <= '0;
            cnt            <= '0;
            hi_shadow      <= '0;
        end else begin
            bus.ReadData   <= mis_c ? '0 : ext_c;
            bus.Misaligned <= mis_c;
            cnt            <= cnt + CNT_W'(1);
            if (lo_hit_c) hi_shadow <= cnt[63:32];
            if (do_store_c && led_hit_c) leds <= led_next_c;
        end
    end

endmodule
